// File: rtl/restoring_divider_pkg.sv
// Shared types and constants for the restoring divider.
//   state_t   : control FSM state encoding (IDLE, SHIFT, SUB, DONE)
//   WIDTH_DEF : default operand width
package div_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SUB   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/restoring_divider_if.sv
// Operand/result bundle for the restoring divider.
//   Run, Load_B, Din                    : request side (master drives)
//   Quotient, Remainder, Divisor        : result/display registers (slave drives)
//   Busy, Done, Div_Zero                : status (slave drives)
interface restoring_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             Run;
  logic             Load_B;
  logic [WIDTH-1:0] Din;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic [WIDTH-1:0] Divisor;
  logic             Busy;
  logic             Done;
  logic             Div_Zero;

  modport master (
    output Run, Load_B, Din,
    input  Quotient, Remainder, Divisor, Busy, Done, Div_Zero
  );

  modport slave (
    input  Run, Load_B, Din,
    output Quotient, Remainder, Divisor, Busy, Done, Div_Zero
  );

endinterface

// File: rtl/restoring_divider_control.sv
// Control FSM and step counter for the restoring divider.
//   Clk, Reset     : clock, async active-high reset
//   Run, Load_B    : operator requests
//   b_is_zero      : divisor register is zero
//   ld_b           : load divisor this cycle
//   start          : begin a normal division (capture dividend)
//   start_zero     : divide-by-zero shortcut result
//   shift_en       : shift {R,Q} left
//   sub_en         : trial subtract / restore step
//   Busy, Done     : status decoded from state
//
// state | meaning
// IDLE  | waiting; Load_B loads divisor, Run starts a division
// SHIFT | shift {R,Q} left by one
// SUB   | trial subtract, set Q[0] on success, advance step count
// DONE  | result held until Run drops
module div_control
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic Load_B,
  input  logic b_is_zero,
  output logic ld_b,
  output logic start,
  output logic start_zero,
  output logic shift_en,
  output logic sub_en,
  output logic Busy,
  output logic Done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_count;

  always_comb begin
    w_next     = r_state;
    ld_b       = 1'b0;
    start      = 1'b0;
    start_zero = 1'b0;
    shift_en   = 1'b0;
    sub_en     = 1'b0;
    case (r_state)
      IDLE: begin
        // Load_B wins over Run so a simultaneous request only loads B.
        if (Load_B) begin
          ld_b = 1'b1;
        end else if (Run) begin
          if (b_is_zero) begin
            start_zero = 1'b1;
            w_next     = DONE;
          end else begin
            start  = 1'b1;
            w_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        w_next   = SUB;
      end
      SUB: begin
        sub_en = 1'b1;
        w_next = (r_count == LAST) ? DONE : SHIFT;
      end
      DONE: begin
        // Run must return low before another division can start.
        if (!Run) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (start)       r_count <= '0;
      else if (sub_en) r_count <= r_count + CW'(1);
    end
  end

  assign Busy = (r_state == SHIFT) || (r_state == SUB);
  assign Done = (r_state == DONE);

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider (shift / trial-subtract).
//   Clk, Reset : clock, async active-high reset
//   bus        : slave side of restoring_divider_if
//                (Run, Load_B, Din in; Quotient, Remainder, Divisor,
//                 Busy, Done, Div_Zero out)
// Holds the Q/R/B registers and the subtractor; sequencing lives in
// div_control.
module restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                  Clk,
  input  logic                  Reset,
  restoring_divider_if.slave    bus
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_b;
  logic             r_div_zero;

  logic             w_ld_b;
  logic             w_start;
  logic             w_start_zero;
  logic             w_shift_en;
  logic             w_sub_en;
  logic             w_busy;
  logic             w_done;
  logic [WIDTH:0]   w_diff;

  div_control #(.WIDTH(WIDTH)) u_ctrl (
    .Clk        (Clk),
    .Reset      (Reset),
    .Run        (bus.Run),
    .Load_B     (bus.Load_B),
    .b_is_zero  (r_b == '0),
    .ld_b       (w_ld_b),
    .start      (w_start),
    .start_zero (w_start_zero),
    .shift_en   (w_shift_en),
    .sub_en     (w_sub_en),
    .Busy       (w_busy),
    .Done       (w_done)
  );

  // One extra bit so B = 2^WIDTH-1 still compares correctly; the MSB
  // is the borrow.
  assign w_diff = {1'b0, r_r} - {1'b0, r_b};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_q        <= '0;
      r_r        <= '0;
      r_b        <= '0;
      r_div_zero <= 1'b0;
    end else begin
      if (w_ld_b) r_b <= bus.Din;
      if (w_start) begin
        r_q        <= bus.Din;
        r_r        <= '0;
        r_div_zero <= 1'b0;
      end
      if (w_start_zero) begin
        r_q        <= '1;
        r_r        <= bus.Din;
        r_div_zero <= 1'b1;
      end
      // R < B before every shift, so R's top bit is always 0 and can drop.
      if (w_shift_en) {r_r, r_q} <= {r_r[WIDTH-2:0], r_q, 1'b0};
      if (w_sub_en && !w_diff[WIDTH]) begin
        r_r    <= w_diff[WIDTH-1:0];
        r_q[0] <= 1'b1;
      end
    end
  end

  assign bus.Quotient  = r_q;
  assign bus.Remainder = r_r;
  assign bus.Divisor   = r_b;
  assign bus.Div_Zero  = r_div_zero;
  assign bus.Busy      = w_busy;
  assign bus.Done      = w_done;

endmodule

// File: tb/tb_restoring_divider.sv
module tb_restoring_divider;

  localparam int W = 8;

  logic Clk = 1'b0;
  logic Reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   cmp_on  = 0;

  always #5 Clk = ~Clk;

  restoring_divider_if #(.WIDTH(W)) bus ();

  restoring_divider #(.WIDTH(W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: operand-level arithmetic plus a cycle budget.
  int         m_phase;   // 0 idle, 1 busy, 2 done
  int         m_left;
  logic [7:0] m_b, m_q, m_r;
  logic       m_dz;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_phase = 0; m_left = 0; m_b = 0; m_q = 0; m_r = 0; m_dz = 0;
    end else begin
      case (m_phase)
        0: begin
          if (bus.Load_B) m_b = bus.Din;
          else if (bus.Run) begin
            if (m_b != 0) begin
              m_q = bus.Din / m_b;
              m_r = bus.Din % m_b;
              m_dz = 0;
              m_left = 2 * W;
              m_phase = 1;
            end else begin
              m_q = 8'hFF;
              m_r = bus.Din;
              m_dz = 1;
              m_phase = 2;
            end
          end
        end
        1: begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: if (!bus.Run) m_phase = 0;
      endcase
    end
  end

  always @(negedge Clk) begin
    if (cmp_on) begin
      check("busy", bus.Busy, m_phase == 1);
      check("done", bus.Done, m_phase == 2);
      check("divisor", bus.Divisor, m_b);
      if (m_phase != 1) begin
        check("quotient", bus.Quotient, m_q);
        check("remainder", bus.Remainder, m_r);
        check("div_zero", bus.Div_Zero, m_dz);
      end else begin
        check("div_zero_busy", bus.Div_Zero, 0);
      end
    end
  end

  task automatic wait_done(output int lat, output int busy_n);
    bit seen = 0;
    lat = 0; busy_n = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge Clk); #1;
      lat++;
      if (bus.Busy) busy_n++;
      if (bus.Done) seen = 1;
    end
    check("done_reached", seen, 1);
  endtask

  task automatic run_div(input logic do_load, input logic [7:0] b_val, input logic [7:0] dvd,
                         input int hold, output int lat, output int busy_n, output int hold_bad);
    if (do_load) begin
      @(negedge Clk); bus.Load_B = 1; bus.Din = b_val;
    end
    @(negedge Clk); bus.Load_B = 0; bus.Din = dvd; bus.Run = 1;
    wait_done(lat, busy_n);
    hold_bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      if (!bus.Done || bus.Busy) hold_bad++;
    end
    @(negedge Clk); bus.Run = 0;
    @(negedge Clk);
  endtask

  int lat, bsy, hb;

  initial begin
    Reset = 1; bus.Run = 0; bus.Load_B = 0; bus.Din = 0;
    repeat (2) @(negedge Clk);
    check("rst_quotient", bus.Quotient, 0);
    check("rst_remainder", bus.Remainder, 0);
    check("rst_divisor", bus.Divisor, 0);
    check("rst_status", {bus.Busy, bus.Done, bus.Div_Zero}, 0);
    cmp_on = 1;
    Reset = 0;

    run_div(1, 8'd7, 8'd100, 0, lat, bsy, hb);
    check("lat_7_100", lat, 17);
    check("busy_7_100", bsy, 16);
    check("q_7_100", bus.Quotient, 14);
    check("r_7_100", bus.Remainder, 2);
    check("dz_7_100", bus.Div_Zero, 0);

    run_div(1, 8'd1, 8'd255, 0, lat, bsy, hb);
    check("q_1_255", bus.Quotient, 255);
    check("r_1_255", bus.Remainder, 0);
    check("lat_1_255", lat, 17);

    run_div(1, 8'd255, 8'd255, 0, lat, bsy, hb);
    check("q_255_255", bus.Quotient, 1);
    check("r_255_255", bus.Remainder, 0);

    run_div(1, 8'd9, 8'd5, 0, lat, bsy, hb);
    check("q_9_5", bus.Quotient, 0);
    check("r_9_5", bus.Remainder, 5);

    run_div(1, 8'd0, 8'h3C, 0, lat, bsy, hb);
    check("lat_div0", lat, 1);
    check("busy_div0", bsy, 0);
    check("q_div0", bus.Quotient, 8'hFF);
    check("r_div0", bus.Remainder, 8'h3C);
    check("dz_div0", bus.Div_Zero, 1);

    run_div(1, 8'd7, 8'd100, 40, lat, bsy, hb);
    check("hold_in_done", hb, 0);
    check("q_hold", bus.Quotient, 14);
    run_div(0, 8'd0, 8'd100, 0, lat, bsy, hb);
    check("lat_rerun", lat, 17);
    check("q_rerun", bus.Quotient, 14);
    check("r_rerun", bus.Remainder, 2);

    // Async reset partway through a division.
    @(negedge Clk); bus.Load_B = 1; bus.Din = 8'd7;
    @(negedge Clk); bus.Load_B = 0; bus.Din = 8'd100; bus.Run = 1;
    repeat (7) @(posedge Clk);
    #3;
    Reset = 1; bus.Run = 0;
    #1;
    check("arst_quotient", bus.Quotient, 0);
    check("arst_remainder", bus.Remainder, 0);
    check("arst_divisor", bus.Divisor, 0);
    check("arst_status", {bus.Busy, bus.Done, bus.Div_Zero}, 0);
    @(negedge Clk);
    @(negedge Clk); Reset = 0;
    @(negedge Clk);
    check("post_rst_divisor", bus.Divisor, 0);
    check("post_rst_busy", bus.Busy, 0);

    // Load_B while busy is ignored.
    @(negedge Clk); bus.Load_B = 1; bus.Din = 8'd9;
    @(negedge Clk); bus.Load_B = 0; bus.Din = 8'd100; bus.Run = 1;
    repeat (3) @(negedge Clk);
    bus.Load_B = 1; bus.Din = 8'd3;
    repeat (2) @(negedge Clk);
    bus.Load_B = 0;
    check("busy_load_divisor", bus.Divisor, 9);
    wait_done(lat, bsy);
    check("q_busy_load", bus.Quotient, 11);
    check("r_busy_load", bus.Remainder, 1);
    @(negedge Clk); bus.Run = 0;
    @(negedge Clk);

    // Load_B and Run together: load only, start on the next edge.
    bus.Load_B = 1; bus.Din = 8'd5; bus.Run = 1;
    @(negedge Clk);
    bus.Load_B = 0; bus.Din = 8'd47;
    check("combo_no_start", bus.Busy, 0);
    check("combo_divisor", bus.Divisor, 5);
    wait_done(lat, bsy);
    check("lat_combo", lat, 17);
    check("q_combo", bus.Quotient, 9);
    check("r_combo", bus.Remainder, 2);
    @(negedge Clk); bus.Run = 0;
    repeat (2) @(negedge Clk);

    cmp_on = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
